// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA capture path and the VGA timing generator.
//   cap_state_e   : capture FSM state encoding (also exported on state_dbg)
//   H_ACTIVE_DEF  : default active pixels per line
//   V_ACTIVE_DEF  : default active lines per frame
//   rgb332()      : 24-bit colour to 8-bit RGB332 reduction
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // Keep the top 3 bits of red and green and the top 2 bits of blue.
    function automatic logic [7:0] rgb332(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// -----------------------------------------------------------------------------
// pixel_packer
// Packs four 8-bit pixels into one 32-bit word, little-endian: the first
// pixel of a word lands in [7:0], the fourth in [31:24].
//
// Handshake: valid_i only, no back-pressure. The packer accepts pix_i in
// every cycle valid_i=1. word_valid_o is a single-cycle pulse in the cycle
// after the fourth pixel was accepted, with word_o holding the packed word;
// word_o keeps its value until the next completed word.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   clear_i      : drop any partially packed word (start of a new frame)
//   pix_i        : RGB332 pixel
//   valid_i      : pix_i is a pixel to pack
//   word_o       : last completed 32-bit word
//   word_valid_o : one-cycle pulse, word_o is new
// -----------------------------------------------------------------------------
module pixel_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic [7:0]  pix_i,
    input  logic        valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    // sr_q holds up to three earlier pixels; the newest sits in [23:16] and
    // older ones shift toward [7:0], so the oldest ends up lowest.
    logic [23:0] sr_q, sr_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        sr_d         = sr_q;
        idx_d        = idx_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear_i) begin
            idx_d = 2'd0;
        end else if (valid_i) begin
            if (idx_q == 2'd3) begin
                word_d       = {pix_i, sr_q};
                word_valid_d = 1'b1;
                idx_d        = 2'd0;
            end else begin
                sr_d  = {pix_i, sr_q[23:8]};
                idx_d = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q         <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/vga_capture.sv
// -----------------------------------------------------------------------------
// vga_capture
// Captures one VGA frame into a framebuffer RAM, decimated 4x in both
// directions and reduced to RGB332, four pixels per 32-bit RAM word.
//
// Ports
//   clk, reset            : clock (rising edge), async active-high reset
//   pix_en                : pixel strobe; video inputs are sampled only here
//   vga_hs/vga_vs         : active-low syncs (hsync is not needed for capture)
//   vga_blank             : 1 = active video, 0 = blanking
//   vga_r/vga_g/vga_b     : 8-bit colour
//   arm / abort           : start-capture / cancel pulses
//   busy, done, err       : status
//   wr_addr/wr_data/wr_en : RAM write port, one-cycle wr_en per word
//   state_dbg             : current FSM state (cap_state_e encoding)
// -----------------------------------------------------------------------------
module vga_capture
    import vga_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int BASE_ADDR     = 0,
    parameter int H_ACTIVE      = H_ACTIVE_DEF,
    parameter int V_ACTIVE      = V_ACTIVE_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_en,
    input  logic                     vga_hs,
    input  logic                     vga_vs,
    input  logic                     vga_blank,
    input  logic [7:0]               vga_r,
    input  logic [7:0]               vga_g,
    input  logic [7:0]               vga_b,
    input  logic                     arm,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [31:0]              wr_data,
    output logic                     wr_en,
    output logic [1:0]               state_dbg
);

    localparam int CNT_MAX = (H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]         X_FULL = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]         Y_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BASE   = ADDRESS_WIDTH'(BASE_ADDR);

    cap_state_e               state_q, state_d;
    logic                     vs_q, blank_q;
    logic [CNT_W-1:0]         x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0]         y_cnt_q, y_cnt_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic        vs_fall, blank_fall, active, keep, pack_clear;
    logic [7:0]  pix332;
    logic [31:0] pack_word;
    logic        pack_valid;
    logic        unused_hs;

    assign unused_hs = vga_hs;

    // Edges are seen only between consecutive strobed samples.
    assign vs_fall    = pix_en & vs_q & ~vga_vs;
    assign blank_fall = pix_en & blank_q & ~vga_blank;
    assign active     = pix_en & vga_blank;
    assign pix332     = rgb332(vga_r, vga_g, vga_b);

    // x_cnt saturates at H_ACTIVE on an over-long line, so the x_cnt != X_FULL
    // term also suppresses kept pixels until the next blank edge. A pixel on a
    // vsync-edge sample or under abort is never packed.
    assign keep = (state_q == ST_CAPTURE) & active & ~abort & ~vs_fall &
                  (x_cnt_q != X_FULL) &
                  (x_cnt_q[1:0] == 2'd0) & (y_cnt_q[1:0] == 2'd0);

    always_comb begin
        state_d    = state_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        ptr_d      = ptr_q;
        done_d     = done_q;
        err_d      = err_q;
        pack_clear = 1'b0;

        if (pack_valid) begin
            ptr_d = ptr_q + ADDRESS_WIDTH'(1);
        end

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d = ST_WAIT_VS;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        ptr_d   = BASE;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_fall) begin
                        state_d    = ST_CAPTURE;
                        x_cnt_d    = '0;
                        y_cnt_d    = '0;
                        pack_clear = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // Completion is checked before vsync so that a frame
                    // ending on the same sample as a vsync edge is clean.
                    if (blank_fall && (y_cnt_q == Y_LAST)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        y_cnt_d = y_cnt_q + CNT_W'(1);
                        x_cnt_d = '0;
                    end else if (vs_fall) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (blank_fall) begin
                        x_cnt_d = '0;
                        y_cnt_d = y_cnt_q + CNT_W'(1);
                    end else if (active) begin
                        if (x_cnt_q == X_FULL) begin
                            err_d = 1'b1;
                        end else begin
                            x_cnt_d = x_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (pix_en) begin
                vs_q    <= vga_vs;
                blank_q <= vga_blank;
            end
        end
    end

    pixel_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pack_clear),
        .pix_i        (pix332),
        .valid_i      (keep),
        .word_o       (pack_word),
        .word_valid_o (pack_valid)
    );

    assign busy      = (state_q == ST_WAIT_VS) || (state_q == ST_CAPTURE);
    assign done      = done_q;
    assign err       = err_q;
    assign wr_en     = pack_valid;
    assign wr_data   = pack_word;
    assign wr_addr   = ptr_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vga_capture.sv
// -----------------------------------------------------------------------------
// tb_vga_capture
// Directed bench for vga_capture on a reduced 64x48 geometry (16x12 output,
// 48 words per frame) with a 6-bit address and BASE_ADDR=40 so that every
// frame wraps the word pointer. Expected RAM writes are pushed when the
// pixels are driven and popped when wr_en fires.
// -----------------------------------------------------------------------------
module tb_vga_capture;
    import vga_pkg::*;

    localparam int AW    = 6;
    localparam int BASE  = 40;
    localparam int H     = 64;
    localparam int V     = 48;
    localparam int WORDS = (H / 4) * (V / 4) / 4;
    localparam int W     = AW + 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_en;
    logic          vga_hs, vga_vs, vga_blank;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          arm, abort;
    logic          busy, done, err;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_en;
    logic [1:0]    state_dbg;

    vga_capture #(
        .ADDRESS_WIDTH (AW),
        .BASE_ADDR     (BASE),
        .H_ACTIVE      (H),
        .V_ACTIVE      (V)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .vga_hs    (vga_hs),
        .vga_vs    (vga_vs),
        .vga_blank (vga_blank),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .arm       (arm),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            wr_count    = 0;
    bit            first_seen  = 1'b0;
    logic [31:0]   first_data  = '0;
    logic [AW-1:0] last_addr   = '0;
    logic [W-1:0]  mon_e;
    bit            mon_has;

    // bench model of the packing
    int            m_ptr = BASE;
    int            m_idx = 0;
    logic [31:0]   m_word = '0;
    logic [23:0]   fixed_px [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to332(input logic [23:0] rgb);
        return {rgb[23:21], rgb[15:13], rgb[7:6]};
    endfunction

    function automatic logic [23:0] colour(input int x, input int y);
        logic [23:0] c;
        if (y == 0 && x < 16 && (x % 4) == 0) c = fixed_px[x / 4];
        else c = 24'($urandom);
        return c;
    endfunction

    task automatic model_keep(input logic [23:0] rgb);
        m_word[8*m_idx +: 8] = to332(rgb);
        m_idx++;
        if (m_idx == 4) begin
            exp_q.push_back({AW'(m_ptr), m_word});
            m_ptr  = (m_ptr + 1) % (1 << AW);
            m_idx  = 0;
            m_word = '0;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_count++;
            last_addr = wr_addr;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_data = wr_data;
            end
            mon_has = (exp_q.size() > 0);
            check("wr_expected", 64'(mon_has), 64'd1);
            if (mon_has) begin
                mon_e = exp_q.pop_front();
                check("wr_addr_data", 64'({wr_addr, wr_data}), 64'(mon_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One strobed sample, preceded by 0..1 unstrobed cycles carrying junk.
    task automatic pix(input logic vs, input logic blank, input logic [23:0] rgb, input logic ab);
        int gap;
        gap = $urandom_range(0, 1);
        repeat (gap) begin
            @(posedge clk); #1;
            pix_en    = 1'b0;
            abort     = 1'b0;
            vga_vs    = 1'($urandom);
            vga_blank = 1'($urandom);
            vga_hs    = 1'($urandom);
            {vga_r, vga_g, vga_b} = 24'($urandom);
        end
        @(posedge clk); #1;
        pix_en    = 1'b1;
        vga_vs    = vs;
        vga_blank = blank;
        vga_hs    = 1'b1;
        {vga_r, vga_g, vga_b} = rgb;
        abort     = ab;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pix_en = 1'b0;
            abort  = 1'b0;
            arm    = 1'b0;
        end
    endtask

    task automatic do_arm();
        @(posedge clk); #1;
        pix_en = 1'b0;
        abort  = 1'b0;
        arm    = 1'b1;
        @(posedge clk); #1;
        arm    = 1'b0;
        m_ptr  = BASE;
    endtask

    task automatic vsync_preamble();
        pix(1'b1, 1'b0, 24'h0, 1'b0);
        pix(1'b1, 1'b0, 24'h0, 1'b0);
        pix(1'b0, 1'b0, 24'h0, 1'b0);
        pix(1'b0, 1'b0, 24'h0, 1'b0);
        pix(1'b1, 1'b0, 24'h0, 1'b0);
        pix(1'b1, 1'b0, 24'h0, 1'b0);
    endtask

    task automatic send_active(input int x, input int y, input bit cap);
        logic [23:0] c;
        c = colour(x, y);
        pix(1'b1, 1'b1, c, 1'b0);
        if (cap && x < H && (x % 4) == 0 && (y % 4) == 0) model_keep(c);
    endtask

    // n_lines full lines, then tail_px pixels of one more line; line 0 gets
    // extra_px0 surplus pixels; busy_arm pulses arm after line 1; vs_at_end
    // drops vsync on the sample that completes the last line.
    task automatic frame(input int n_lines, input int tail_px, input int extra_px0,
                         input bit cap, input bit busy_arm, input bit vs_at_end);
        m_idx  = 0;
        m_word = '0;
        vsync_preamble();
        for (int y = 0; y < n_lines; y++) begin
            for (int x = 0; x < H + ((y == 0) ? extra_px0 : 0); x++) send_active(x, y, cap);
            pix((vs_at_end && y == n_lines - 1) ? 1'b0 : 1'b1, 1'b0, 24'h0, 1'b0);
            pix(1'b1, 1'b0, 24'h0, 1'b0);
            pix(1'b1, 1'b0, 24'h0, 1'b0);
            if (busy_arm && y == 1) begin
                @(posedge clk); #1;
                pix_en = 1'b0;
                arm    = 1'b1;
                @(posedge clk); #1;
                arm    = 1'b0;
            end
        end
        for (int x = 0; x < tail_px; x++) send_active(x, n_lines, cap);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; pix_en = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank = 1'b0;
        vga_r = '0; vga_g = '0; vga_b = '0; arm = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_addr",  64'(wr_addr), 64'd0);
        check("rst_data",  64'(wr_data), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        reset = 1'b0;
        idle(3);

        // full frame
        wr_count = 0;
        do_arm();
        check("f1_busy_armed", 64'(busy), 64'd1);
        check("f1_state_wait", 64'(state_dbg), 64'(ST_WAIT_VS));
        frame(V, 0, 0, 1'b1, 1'b0, 1'b0);
        idle(6);
        check("f1_done",       64'(done), 64'd1);
        check("f1_err",        64'(err), 64'd0);
        check("f1_busy",       64'(busy), 64'd0);
        check("f1_state",      64'(state_dbg), 64'(ST_DONE));
        check("f1_writes",     64'(wr_count), 64'(WORDS));
        check("f1_pending",    64'(exp_q.size()), 64'd0);
        check("f1_first_word", 64'(first_data), 64'hFF031CE0);
        check("f1_last_addr",  64'(last_addr), 64'((BASE + WORDS - 1) % (1 << AW)));

        // re-arm from DONE; arm during capture ignored; vsync on completion sample
        wr_count = 0;
        do_arm();
        check("f2_done_clr", 64'(done), 64'd0);
        frame(V, 0, 0, 1'b1, 1'b1, 1'b1);
        idle(6);
        check("f2_done",    64'(done), 64'd1);
        check("f2_err",     64'(err), 64'd0);
        check("f2_writes",  64'(wr_count), 64'(WORDS));
        check("f2_pending", 64'(exp_q.size()), 64'd0);

        // over-long first line
        wr_count = 0;
        do_arm();
        frame(V, 0, 5, 1'b1, 1'b0, 1'b0);
        idle(6);
        check("ovf_done",    64'(done), 64'd1);
        check("ovf_err",     64'(err), 64'd1);
        check("ovf_writes",  64'(wr_count), 64'(WORDS));
        check("ovf_pending", 64'(exp_q.size()), 64'd0);

        // early vsync after 16 lines plus a partial word
        wr_count = 0;
        do_arm();
        check("vs_err_clr", 64'(err), 64'd0);
        frame(16, 6, 0, 1'b1, 1'b0, 1'b0);
        pix(1'b0, 1'b0, 24'h0, 1'b0);
        idle(6);
        check("vs_err",     64'(err), 64'd1);
        check("vs_done",    64'(done), 64'd1);
        check("vs_state",   64'(state_dbg), 64'(ST_DONE));
        check("vs_writes",  64'(wr_count), 64'd16);
        check("vs_pending", 64'(exp_q.size()), 64'd0);

        // abort from DONE keeps done/err
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check("abd_state", 64'(state_dbg), 64'(ST_IDLE));
        check("abd_done",  64'(done), 64'd1);
        check("abd_err",   64'(err), 64'd1);

        // abort on the 4th kept pixel
        wr_count = 0;
        do_arm();
        vsync_preamble();
        for (int x = 0; x < 12; x++) pix(1'b1, 1'b1, 24'($urandom), 1'b0);
        pix(1'b1, 1'b1, 24'($urandom), 1'b1);
        idle(4);
        check("ab_state",  64'(state_dbg), 64'(ST_IDLE));
        check("ab_busy",   64'(busy), 64'd0);
        check("ab_writes", 64'(wr_count), 64'd0);

        // reset mid-capture, then a frame without arm
        wr_count = 0;
        do_arm();
        frame(8, 10, 0, 1'b1, 1'b0, 1'b0);
        check("mr_state",   64'(state_dbg), 64'(ST_CAPTURE));
        check("mr_writes",  64'(wr_count), 64'd8);
        check("mr_pending", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        wr_count = 0;
        frame(V, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(6);
        check("na_writes", 64'(wr_count), 64'd0);
        check("na_busy",   64'(busy), 64'd0);
        check("na_done",   64'(done), 64'd0);
        check("na_err",    64'(err), 64'd0);
        check("na_addr",   64'(wr_addr), 64'd0);
        check("na_data",   64'(wr_data), 64'd0);
        check("na_state",  64'(state_dbg), 64'(ST_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
